// File: rtl/loadarch_inject_sequencer.sv
// Restores an architectural checkpoint into a core held in reset: streams
// {kind, index, data} records into XPR/FPR/CSR/PC write ports, then releases core_reset.
module loadarch_inject_sequencer #(
  parameter int unsigned XLEN          = 64,
  parameter int unsigned CSR_ADDR_W    = 12,
  parameter int unsigned RELEASE_DELAY = 4,
  parameter int unsigned CSR_TIMEOUT   = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            in_kind,
  input  logic [CSR_ADDR_W-1:0] in_index,
  input  logic [XLEN-1:0]       in_data,
  input  logic                  in_last,
  output logic                  xpr_wen,
  output logic [4:0]            xpr_waddr,
  output logic [XLEN-1:0]       xpr_wdata,
  output logic                  fpr_wen,
  output logic [4:0]            fpr_waddr,
  output logic [XLEN-1:0]       fpr_wdata,
  output logic                  csr_req,
  output logic [CSR_ADDR_W-1:0] csr_addr,
  output logic [XLEN-1:0]       csr_wdata,
  input  logic                  csr_ack,
  output logic                  pc_wen,
  output logic [XLEN-1:0]       pc_wdata,
  output logic                  core_reset,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [1:0]            err_code,
  output logic [7:0]            wr_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_ACCEPT, S_CSR_WAIT, S_DRAIN, S_DONE, S_ERROR
  } state_t;

  localparam logic [1:0] K_XPR = 2'd0;
  localparam logic [1:0] K_FPR = 2'd1;
  localparam logic [1:0] K_CSR = 2'd2;
  localparam logic [1:0] K_PC  = 2'd3;

  localparam logic [7:0] TIMEOUT_LAST = 8'(CSR_TIMEOUT - 1);
  localparam logic [7:0] RELEASE_LAST = 8'(RELEASE_DELAY - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [1:0] err_nxt;
  logic       do_xpr, do_fpr, do_csr, do_pc, begin_run, bad_idx;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    err_nxt   = '0;
    do_xpr    = 1'b0;
    do_fpr    = 1'b0;
    do_csr    = 1'b0;
    do_pc     = 1'b0;
    begin_run = 1'b0;
    bad_idx   = (in_index[CSR_ADDR_W-1:5] != '0);
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          begin_run = 1'b1;
          state_nxt = S_ACCEPT;
        end
      end
      S_ACCEPT: begin
        if (in_valid) begin
          // in_last must be set on the PC record and on no other record
          if (in_last != (in_kind == K_PC)) begin
            err_nxt   = 2'd3;
            state_nxt = S_ERROR;
          end else begin
            case (in_kind)
              K_XPR, K_FPR: begin
                if (bad_idx) begin
                  err_nxt   = 2'd1;
                  state_nxt = S_ERROR;
                end else begin
                  do_xpr = (in_kind == K_XPR) && (in_index[4:0] != 5'd0);
                  do_fpr = (in_kind == K_FPR);
                end
              end
              K_CSR: begin
                do_csr    = 1'b1;
                state_nxt = S_CSR_WAIT;
              end
              default: begin
                do_pc     = 1'b1;
                state_nxt = S_DRAIN;
              end
            endcase
          end
        end
      end
      S_CSR_WAIT: begin
        if (csr_ack) begin
          state_nxt = S_ACCEPT;
        end else if (cnt == TIMEOUT_LAST) begin
          err_nxt   = 2'd2;
          state_nxt = S_ERROR;
        end
      end
      S_DRAIN: begin
        if (cnt == RELEASE_LAST) state_nxt = S_DONE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == S_ACCEPT);
    busy       = (state == S_ACCEPT) || (state == S_CSR_WAIT) || (state == S_DRAIN);
    csr_req    = (state == S_CSR_WAIT);
    core_reset = (state != S_DONE);
    done       = (state == S_DONE);
    error      = (state == S_ERROR);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      xpr_wen   <= 1'b0;
      xpr_waddr <= '0;
      xpr_wdata <= '0;
      fpr_wen   <= 1'b0;
      fpr_waddr <= '0;
      fpr_wdata <= '0;
      csr_addr  <= '0;
      csr_wdata <= '0;
      pc_wen    <= 1'b0;
      pc_wdata  <= '0;
      cnt       <= '0;
      err_code  <= '0;
      wr_count  <= '0;
    end else begin
      xpr_wen <= do_xpr;
      fpr_wen <= do_fpr;
      pc_wen  <= do_pc;
      if (do_xpr) begin
        xpr_waddr <= in_index[4:0];
        xpr_wdata <= in_data;
      end
      if (do_fpr) begin
        fpr_waddr <= in_index[4:0];
        fpr_wdata <= in_data;
      end
      if (do_csr) begin
        csr_addr  <= in_index;
        csr_wdata <= in_data;
      end
      if (do_pc) pc_wdata <= in_data;
      // Shared counter: CSR wait age or release delay, zeroed on every state change
      if ((state == S_CSR_WAIT || state == S_DRAIN) && state_nxt == state) cnt <= cnt + 8'd1;
      else                                                                 cnt <= '0;
      if (begin_run) begin
        err_code <= '0;
        wr_count <= '0;
      end else begin
        if (err_nxt != 2'd0) err_code <= err_nxt;
        if ((do_xpr || do_fpr || do_pc || (state == S_CSR_WAIT && csr_ack)) && wr_count != 8'hFF)
          wr_count <= wr_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_loadarch_inject_sequencer.sv
// Scenario bench for loadarch_inject_sequencer: directed scenarios plus randomized
// record streams checked against a record-level model of the expected writes.
module tb_loadarch_inject_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_kind = '0;
  logic [11:0] in_index = '0;
  logic [63:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        xpr_wen, fpr_wen, csr_req, pc_wen;
  logic [4:0]  xpr_waddr, fpr_waddr;
  logic [63:0] xpr_wdata, fpr_wdata, csr_wdata, pc_wdata;
  logic [11:0] csr_addr;
  logic        csr_ack = 1'b0;
  logic        core_reset, busy, done, error;
  logic [1:0]  err_code;
  logic [7:0]  wr_count;

  always #5 clock = ~clock;

  loadarch_inject_sequencer #(
    .XLEN(64), .CSR_ADDR_W(12), .RELEASE_DELAY(4), .CSR_TIMEOUT(255)
  ) dut (
    .clock(clock), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
    .in_index(in_index), .in_data(in_data), .in_last(in_last),
    .xpr_wen(xpr_wen), .xpr_waddr(xpr_waddr), .xpr_wdata(xpr_wdata),
    .fpr_wen(fpr_wen), .fpr_waddr(fpr_waddr), .fpr_wdata(fpr_wdata),
    .csr_req(csr_req), .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_ack(csr_ack),
    .pc_wen(pc_wen), .pc_wdata(pc_wdata), .core_reset(core_reset),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .wr_count(wr_count)
  );

  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [63:0] data;
    int          cyc;
  } wr_t;

  wr_t obs[$];
  wr_t exp_q[$];
  int  cyc = 0;
  int  pc_cyc = -1;
  int  fall_cyc = -1;
  int  req_seen = 0;
  logic prev_cr = 1'b1;
  int  n_cmp = 0;
  int  n_err = 0;
  int  ack_delay = 1000;
  int  req_age = 0;

  logic [1:0]  rk[16];
  logic [11:0] ri[16];
  logic [63:0] rd[16];
  logic        rl[16];

  // Write-port observer
  always @(negedge clock) begin
    cyc++;
    if (xpr_wen) obs.push_back('{kind: 0, addr: {7'd0, xpr_waddr}, data: xpr_wdata, cyc: cyc});
    if (fpr_wen) obs.push_back('{kind: 1, addr: {7'd0, fpr_waddr}, data: fpr_wdata, cyc: cyc});
    if (csr_req && csr_ack) obs.push_back('{kind: 2, addr: csr_addr, data: csr_wdata, cyc: cyc});
    if (pc_wen) begin
      obs.push_back('{kind: 3, addr: 12'd0, data: pc_wdata, cyc: cyc});
      pc_cyc = cyc;
    end
    if (csr_req) req_seen++;
    if (prev_cr && !core_reset) fall_cyc = cyc;
    prev_cr = core_reset;
  end

  // CSR file responder: acks ack_delay cycles into a request
  always @(posedge clock) begin
    #1;
    if (csr_req) begin
      req_age++;
      csr_ack = (req_age == ack_delay);
    end else begin
      req_age = 0;
      csr_ack = 1'b0;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required $finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic clear_log();
    obs.delete();
    exp_q.delete();
    pc_cyc   = -1;
    fall_cyc = -1;
    req_seen = 0;
  endtask

  task automatic push_exp(input int k, input logic [11:0] a, input logic [63:0] d);
    exp_q.push_back('{kind: k, addr: a, data: d, cyc: 0});
  endtask

  function automatic int first_diff();
    if (obs.size() != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (obs[i].kind != exp_q[i].kind || obs[i].addr !== exp_q[i].addr || obs[i].data !== exp_q[i].data)
        return i;
    return -1;
  endfunction

  task automatic send(input logic [1:0] k, input logic [11:0] idx, input logic [63:0] d,
                      input logic last, input int gap);
    bit acc;
    acc = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_kind  = k;
    in_index = idx;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 500 && !acc; t++) begin
      @(negedge clock);
      if (in_ready) acc = 1'b1;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if (!acc) begin
      n_err++;
      $display("FAIL send_accept: in_ready stayed 0 for 500 cycles (kind %0d idx %0h), required 1", k, idx);
    end
  endtask

  task automatic wait_end(input int limit);
    bit hit;
    hit = 1'b0;
    for (int t = 0; t < limit && !hit; t++) begin
      if (done || error) hit = 1'b1;
      else tick();
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL wait_end: done=%0b error=%0b after %0d cycles, required one set", done, error, limit);
    end
  endtask

  function automatic logic any_out();
    return |{in_ready, xpr_wen, xpr_waddr, xpr_wdata, fpr_wen, fpr_waddr, fpr_wdata,
             csr_req, csr_addr, csr_wdata, pc_wen, pc_wdata, busy, done, error, err_code, wr_count};
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (core_reset !== 1'b1) begin n_err++; $display("FAIL reset_core_reset: got %b, required 1", core_reset); end
    n_cmp++;
    if (any_out() !== 1'b0) begin n_err++; $display("FAIL reset_outputs: OR of outputs %b, required 0", any_out()); end
    reset = 1'b0;
    tick();
    n_cmp++;
    if (in_ready !== 1'b0 || core_reset !== 1'b1) begin
      n_err++; $display("FAIL idle_after_reset: in_ready=%b core_reset=%b, required 0/1", in_ready, core_reset);
    end
  endtask

  task automatic test_happy_path();
    int d;
    clear_log();
    ack_delay = 2;
    pulse_start();
    send(2'd0, 12'd1, 64'h11, 1'b0, 0);
    send(2'd1, 12'd3, 64'h33, 1'b0, 1);
    send(2'd2, 12'h300, 64'hA00, 1'b0, 0);
    send(2'd3, 12'd0, 64'h8000_0000, 1'b1, 0);
    push_exp(0, 12'd1, 64'h11);
    push_exp(1, 12'd3, 64'h33);
    push_exp(2, 12'h300, 64'hA00);
    push_exp(3, 12'd0, 64'h8000_0000);
    wait_end(50);
    tick();
    d = first_diff();
    n_cmp++;
    if (d != -1) begin n_err++; $display("FAIL happy_writes: diff at %0d (%0d seen), required none (4)", d, obs.size()); end
    n_cmp++;
    if (fall_cyc - pc_cyc != 4) begin n_err++; $display("FAIL happy_release: %0d cycles pc_wen->core_reset fall, required 4", fall_cyc - pc_cyc); end
    n_cmp++;
    if (done !== 1'b1 || core_reset !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL happy_done: done=%b core_reset=%b busy=%b, required 1/0/0", done, core_reset, busy);
    end
    n_cmp++;
    if (wr_count !== 8'd4) begin n_err++; $display("FAIL happy_count: wr_count=%0d, required 4", wr_count); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] v;
    bit consec;
    int d;
    clear_log();
    pulse_start();
    for (int i = 1; i < 32; i++) begin
      v = {$urandom, $urandom};
      push_exp(0, 12'(i), v);
      send(2'd0, 12'(i), v, 1'b0, 0);
    end
    send(2'd0, 12'd0, 64'hDEAD, 1'b0, 0);
    tick();
    tick();
    d = first_diff();
    n_cmp++;
    if (d != -1) begin n_err++; $display("FAIL b2b_writes: diff at %0d (%0d seen), required none (31)", d, obs.size()); end
    consec = 1'b1;
    for (int i = 1; i < obs.size(); i++) if (obs[i].cyc != obs[0].cyc + i) consec = 1'b0;
    n_cmp++;
    if (!consec) begin n_err++; $display("FAIL b2b_consecutive: strobes not on consecutive cycles, required consecutive"); end
    n_cmp++;
    if (wr_count !== 8'd31 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL b2b_count: wr_count=%0d in_ready=%b, required 31/1", wr_count, in_ready);
    end
    send(2'd3, 12'd0, 64'h1000, 1'b1, 0);
    wait_end(50);
    n_cmp++;
    if (done !== 1'b1 || wr_count !== 8'd32) begin
      n_err++; $display("FAIL b2b_done: done=%b wr_count=%0d, required 1/32", done, wr_count);
    end
  endtask

  task automatic test_csr_timeout();
    clear_log();
    ack_delay = 1000;
    pulse_start();
    send(2'd2, 12'h7C0, {$urandom, $urandom}, 1'b0, 0);
    wait_end(400);
    tick();
    tick();
    n_cmp++;
    if (req_seen != 255) begin n_err++; $display("FAIL timeout_len: csr_req high %0d cycles, required 255", req_seen); end
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd2 || core_reset !== 1'b1 || in_ready !== 1'b0 || csr_req !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_state: error=%b code=%0d core_reset=%b in_ready=%b csr_req=%b, required 1/2/1/0/0",
               error, err_code, core_reset, in_ready, csr_req);
    end
    n_cmp++;
    if (obs.size() != 0) begin n_err++; $display("FAIL timeout_nowrite: %0d writes, required 0", obs.size()); end
  endtask

  task automatic test_framing();
    clear_log();
    pulse_start();
    send(2'd0, 12'd7, 64'h77, 1'b0, 0);
    send(2'd0, 12'd5, 64'h55, 1'b1, 0);
    tick();
    tick();
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd3 || obs.size() != 1 || wr_count !== 8'd1) begin
      n_err++;
      $display("FAIL framing_err: error=%b code=%0d writes=%0d wr_count=%0d, required 1/3/1/1",
               error, err_code, obs.size(), wr_count);
    end
    pulse_start();
    n_cmp++;
    if (error !== 1'b0 || err_code !== 2'd0 || wr_count !== 8'd0 || in_ready !== 1'b1 || core_reset !== 1'b1) begin
      n_err++;
      $display("FAIL framing_restart: error=%b code=%0d wr_count=%0d in_ready=%b core_reset=%b, required 0/0/0/1/1",
               error, err_code, wr_count, in_ready, core_reset);
    end
    send(2'd0, 12'd2, 64'h22, 1'b0, 0);
    tick();
    n_cmp++;
    if (obs.size() != 2 || wr_count !== 8'd1) begin
      n_err++; $display("FAIL framing_resume: writes=%0d wr_count=%0d, required 2/1", obs.size(), wr_count);
    end
  endtask

  task automatic test_bad_index();
    clear_log();
    pulse_start();
    send(2'd1, 12'd40, 64'h4040, 1'b0, 0);
    tick();
    tick();
    n_cmp++;
    if (error !== 1'b1 || err_code !== 2'd1 || obs.size() != 0) begin
      n_err++; $display("FAIL bad_index: error=%b code=%0d writes=%0d, required 1/1/0", error, err_code, obs.size());
    end
  endtask

  task automatic test_reset_mid_csr();
    clear_log();
    ack_delay = 1000;
    pulse_start();
    send(2'd2, 12'h341, 64'h1234, 1'b0, 0);
    tick();
    tick();
    n_cmp++;
    if (csr_req !== 1'b1) begin n_err++; $display("FAIL midreset_pre: csr_req=%b, required 1", csr_req); end
    #2;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (csr_req !== 1'b0 || core_reset !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL midreset_async: csr_req=%b core_reset=%b busy=%b in_ready=%b, required 0/1/0/0",
               csr_req, core_reset, busy, in_ready);
    end
    n_cmp++;
    if (any_out() !== 1'b0) begin n_err++; $display("FAIL midreset_outputs: OR of outputs %b, required 0", any_out()); end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic model(input int n, output int err_at, output int code, output int nwr);
    exp_q.delete();
    err_at = -1;
    code   = 0;
    nwr    = 0;
    for (int i = 0; i < n; i++) begin
      if ((rk[i] == 2'd3) != rl[i]) begin code = 3; err_at = i; break; end
      if (rk[i] < 2'd2 && ri[i] >= 12'd32) begin code = 1; err_at = i; break; end
      if (!(rk[i] == 2'd0 && ri[i] == 12'd0)) begin
        push_exp(int'(rk[i]), ri[i], rd[i]);
        nwr++;
      end
    end
    if (nwr > 255) nwr = 255;
  endtask

  task automatic test_random();
    int n, err_at, code, nwr, last_i, d;
    for (int r = 0; r < 20; r++) begin
      clear_log();
      n = $urandom_range(3, 12);
      for (int i = 0; i < n; i++) begin
        rd[i] = {$urandom, $urandom};
        if (i == n - 1) begin
          rk[i] = 2'd3;
          ri[i] = 12'd0;
          rl[i] = ($urandom_range(0, 9) != 0);
        end else begin
          rk[i] = 2'($urandom_range(0, 2));
          if (rk[i] == 2'd2) ri[i] = 12'($urandom_range(0, 4095));
          else if ($urandom_range(0, 9) == 0) ri[i] = 12'($urandom_range(32, 4095));
          else ri[i] = 12'($urandom_range(0, 31));
          rl[i] = ($urandom_range(0, 14) == 0);
        end
      end
      model(n, err_at, code, nwr);
      last_i = (err_at >= 0) ? err_at : n - 1;
      ack_delay = $urandom_range(1, 5);
      pulse_start();
      for (int i = 0; i <= last_i; i++) send(rk[i], ri[i], rd[i], rl[i], $urandom_range(0, 2));
      wait_end(60);
      tick();
      tick();
      d = first_diff();
      n_cmp++;
      if (d != -1) begin
        n_err++; $display("FAIL rand%0d_writes: diff at %0d (%0d seen / %0d expected)", r, d, obs.size(), exp_q.size());
      end
      n_cmp++;
      if (code == 0) begin
        if (done !== 1'b1 || core_reset !== 1'b0 || error !== 1'b0) begin
          n_err++; $display("FAIL rand%0d_done: done=%b core_reset=%b error=%b, required 1/0/0", r, done, core_reset, error);
        end
      end else if (error !== 1'b1 || err_code !== 2'(code) || core_reset !== 1'b1) begin
        n_err++; $display("FAIL rand%0d_error: error=%b code=%0d core_reset=%b, required 1/%0d/1", r, error, err_code, core_reset, code);
      end
      n_cmp++;
      if (wr_count !== 8'(nwr)) begin n_err++; $display("FAIL rand%0d_count: wr_count=%0d, required %0d", r, wr_count, nwr); end
    end
  endtask

  initial begin
    test_reset();
    test_happy_path();
    test_back_to_back();
    test_csr_timeout();
    test_framing();
    test_bad_index();
    test_reset_mid_csr();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/loadarch_inject_sequencer.md
Name: loadarch_inject_sequencer

Overview:
- Synthesizable sequencer that restores a captured architectural checkpoint into one core while the core is held in reset, then releases it.
- Consumes a stream of {kind, index, data} records from a checkpoint source (DMI/serial loader), issues writes to the XPR file, FPR file, CSR file and fetch PC, and owns the core reset.
- Sits in the tile reset domain between the loader and the core.

Parameters:
XLEN, 64, data width of all write ports
CSR_ADDR_W, 12, CSR address width
RELEASE_DELAY, 4, cycles between PC write and core_reset deassertion (1..255)
CSR_TIMEOUT, 255, max cycles waiting for csr_ack before error (1..255)

Ports:
clock  in  1  block clock
reset  in  1  asynchronous, active-high reset
start  in  1  pulse: begin injection (honoured in IDLE, DONE, ERROR)
in_valid  in  1  record valid
in_ready  out  1  record accepted when in_valid && in_ready
in_kind  in  2  0=XPR, 1=FPR, 2=CSR, 3=PC
in_index  in  CSR_ADDR_W  register index / CSR address
in_data  in  XLEN  value to write
in_last  in  1  final record marker
xpr_wen  out  1  XPR write strobe
xpr_waddr  out  5  XPR index
xpr_wdata  out  XLEN  XPR data
fpr_wen  out  1  FPR write strobe
fpr_waddr  out  5  FPR index
fpr_wdata  out  XLEN  FPR data
csr_req  out  1  CSR write request, held until csr_ack
csr_addr  out  CSR_ADDR_W  CSR address
csr_wdata  out  XLEN  CSR data
csr_ack  in  1  CSR write complete
pc_wen  out  1  PC write strobe
pc_wdata  out  XLEN  restored PC
core_reset  out  1  reset to core, active-high
busy  out  1  sequencing in progress
done  out  1  injection complete, core running
error  out  1  injection aborted
err_code  out  2  1=bad index, 2=CSR timeout, 3=framing
wr_count  out  8  writes issued, saturates at 255

Behaviour:
- Reset values: core_reset=1; every other output 0; state IDLE.
- States: IDLE, ACCEPT, CSR_WAIT, DRAIN, DONE, ERROR.
- IDLE/DONE/ERROR + start: core_reset=1 next cycle; done, error, err_code and wr_count cleared; enter ACCEPT. start is ignored in ACCEPT, CSR_WAIT and DRAIN.
- busy=1 in ACCEPT, CSR_WAIT and DRAIN. in_ready=1 only in ACCEPT.
- XPR/FPR record:
  - On handshake, wen, waddr=in_index[4:0] and wdata are registered and pulse for exactly 1 cycle in the next cycle. Stay in ACCEPT, so back-to-back records give 1 write per cycle.
  - XPR index 0 is consumed with no strobe and does not increment wr_count.
  - in_index>=32 -> ERROR, err_code=1, no strobe.
- CSR record:
  - Register addr/data; enter CSR_WAIT; csr_req=1 from the next cycle.
  - csr_addr and csr_wdata are stable while csr_req=1.
  - csr_ack is sampled only while csr_req=1. On ack, csr_req=0 next cycle and return to ACCEPT.
  - The timeout counter starts at 0 when csr_req rises. Reaching CSR_TIMEOUT with no ack -> ERROR, err_code=2, csr_req=0.
- PC record: must carry in_last=1. pc_wen pulses 1 cycle next cycle; enter DRAIN.
- Framing errors, both -> ERROR, err_code=3, no write:
  - in_last=1 on a non-PC record.
  - PC record with in_last=0.
- wr_count increments once per issued strobe (xpr_wen, fpr_wen, CSR ack, pc_wen) and saturates at 255.
- DRAIN: counter runs RELEASE_DELAY cycles after the pc_wen cycle. Then core_reset=0, done=1, enter DONE.
- ERROR: core_reset held 1, error=1, err_code held; exit only via start or reset.
- Asynchronous reset mid-sequence: immediate return to IDLE with core_reset=1; in-flight csr_req drops.
- Out-of-range in_kind cannot occur (2 bits, all encodings used).

Test Plan:
- Happy path: start, then XPR1=0x11, FPR3=0x33, CSR 0x300=0xA00, PC 0x80000000 with in_last; csr_ack 2 cycles after req -> strobes in that order, pc_wen once, core_reset falls exactly 4 cycles after pc_wen, done=1, wr_count=4.
- Back-to-back XPR1..XPR31 with in_valid held high -> 31 consecutive xpr_wen cycles with waddr 1..31; an extra XPR0 record yields no strobe; wr_count=31.
- CSR timeout: csr_ack never asserted -> csr_req high for 255 cycles, then error=1, err_code=2, core_reset stays 1, in_ready=0.
- Framing: XPR5 with in_last=1 -> error=1, err_code=3, no xpr_wen. Then start -> error=0, wr_count=0, ACCEPT resumes.
- Bad index: FPR index 40 -> err_code=1, no fpr_wen.
- Assert reset during CSR_WAIT -> csr_req=0 and core_reset=1 immediately; busy=0, in_ready=0; outputs equal reset values.
